cr_prefix_buf_sched: RTL and testbench

Buffer scheduler for the prefix block's four 1 KB staging buffers. It hands free buffers to the front-end writer in ring order and tracks the word count of each fill. Filled blocks go to the back-end reader in fill order through a valid/ready handshake, and each buffer is reclaimed when the reader releases it. It sits between the prefix front-end controller and the prefix engine and is the single owner of buffer state.

---
 rtl/cr_prefix_pkg.sv | 22 ++
 rtl/cr_prefix_buf_slot.sv | 72 +++++++
 rtl/cr_prefix_buf_sched.sv | 145 ++++++++++++++
 tb/tb_cr_prefix_buf_sched.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_prefix_pkg.sv
// Shared types and constants for the prefix block's staging-buffer scheduler.
// Buffer lifecycle: FREE -> FILL -> FULL -> DRAIN -> FREE.
package cr_prefix_pkg;

   localparam int CR_PREFIX_NUM_BUF   = 4;
   localparam int CR_PREFIX_BLK_WORDS = 128;
   localparam int CR_PREFIX_CNT_W     = 8;

   typedef enum logic [1:0] {
      BUF_FREE,
      BUF_FILL,
      BUF_FULL,
      BUF_DRAIN
   } buf_state_e;

   typedef struct packed {
      buf_state_e                 state;
      logic [CR_PREFIX_CNT_W-1:0] cnt;
      logic                       last;
   } slot_info_t;

endpackage

// File: rtl/cr_prefix_buf_slot.sv
// One staging buffer: lifecycle state, word count and end-of-frame flag.
// Strobes are qualified by the current state, so a stray strobe is harmless.
module cr_prefix_buf_slot
   import cr_prefix_pkg::*;
#(
   parameter int BLK_WORDS = CR_PREFIX_BLK_WORDS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       alloc,
   input  logic       wr,
   input  logic       close,
   input  logic       last_in,
   input  logic       take,
   input  logic       rel,
   output slot_info_t info
);

   localparam int CNT_W = CR_PREFIX_CNT_W;

   buf_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;

      if (alloc && state_q == BUF_FREE) begin
         state_d = BUF_FILL;
         cnt_d   = '0;
         last_d  = 1'b0;
      end

      // A word written in the closing cycle is counted before the close.
      if (state_q == BUF_FILL) begin
         if (wr && cnt_q != CNT_W'(BLK_WORDS)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (close) begin
            state_d = BUF_FULL;
            last_d  = last_in;
         end
      end

      if (take && state_q == BUF_FULL) begin
         state_d = BUF_DRAIN;
      end

      if (rel && state_q == BUF_DRAIN) begin
         state_d = BUF_FREE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_FREE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign info = {state_q, cnt_q, last_q};

endmodule

// File: rtl/cr_prefix_buf_sched.sv
// Staging-buffer scheduler: ring-order grants to the front-end writer, in-order
// offers to the back-end reader, out-of-order release back to FREE.
module cr_prefix_buf_sched
   import cr_prefix_pkg::*;
#(
   parameter  int NUM_BUF   = CR_PREFIX_NUM_BUF,
   parameter  int BLK_WORDS = CR_PREFIX_BLK_WORDS,
   localparam int IDX_W     = $clog2(NUM_BUF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fe_req,
   output logic             fe_gnt,
   output logic [IDX_W-1:0] fe_gnt_buf,
   input  logic             fe_wr,
   input  logic             fe_blk_done,
   input  logic             fe_blk_last,
   output logic             be_blk_vld,
   output logic [IDX_W-1:0] be_blk_buf,
   output logic [7:0]       be_blk_words,
   output logic             be_blk_last,
   input  logic             be_blk_rdy,
   input  logic             be_rel,
   input  logic [IDX_W-1:0] be_rel_buf,
   output logic [IDX_W:0]   buf_free_cnt,
   output logic             sched_idle,
   output logic             err_ovf,
   output logic             err_rel
);

   localparam int CNT_W = CR_PREFIX_CNT_W;

   slot_info_t         slot [NUM_BUF];
   logic [NUM_BUF-1:0] alloc_v, wr_v, close_v, take_v, rel_v;

   logic [IDX_W-1:0]   wp_q, wp_d;
   logic [IDX_W-1:0]   rp_q, rp_d;
   logic [IDX_W-1:0]   gnt_buf_q, gnt_buf_d;
   logic               gnt_q, gnt_d;
   logic               err_ovf_q, err_ovf_d;
   logic               err_rel_q, err_rel_d;

   logic               grant, take, rel_ok, cnt_full;
   logic [IDX_W:0]     free_cnt;

   for (genvar g = 0; g < NUM_BUF; g++) begin : g_slot
      cr_prefix_buf_slot #(
         .BLK_WORDS (BLK_WORDS)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .alloc   (alloc_v[g]),
         .wr      (wr_v[g]),
         .close   (close_v[g]),
         .last_in (fe_blk_last),
         .take    (take_v[g]),
         .rel     (rel_v[g]),
         .info    (slot[g])
      );
   end

   always_comb begin
      alloc_v   = '0;
      wr_v      = '0;
      close_v   = '0;
      take_v    = '0;
      rel_v     = '0;
      wp_d      = wp_q;
      rp_d      = rp_q;
      gnt_d     = gnt_q;
      gnt_buf_d = gnt_buf_q;

      // Registered slot state is used, so a same-cycle release never feeds a grant.
      grant    = !gnt_q && fe_req && slot[wp_q].state == BUF_FREE;
      take     = be_blk_vld && be_blk_rdy;
      rel_ok   = be_rel && slot[be_rel_buf].state == BUF_DRAIN;
      cnt_full = slot[gnt_buf_q].cnt == CNT_W'(BLK_WORDS);

      if (grant) begin
         alloc_v[wp_q] = 1'b1;
         gnt_d         = 1'b1;
         gnt_buf_d     = wp_q;
         wp_d          = wp_q + IDX_W'(1);
      end

      if (gnt_q) begin
         wr_v[gnt_buf_q]    = fe_wr;
         close_v[gnt_buf_q] = fe_blk_done;
         if (fe_blk_done) begin
            gnt_d = 1'b0;
         end
      end

      if (take) begin
         take_v[rp_q] = 1'b1;
         rp_d         = rp_q + IDX_W'(1);
      end

      rel_v[be_rel_buf] = rel_ok;

      err_ovf_d = gnt_q ? (fe_wr && cnt_full) : (fe_wr || fe_blk_done);
      err_rel_d = be_rel && !rel_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q      <= '0;
         rp_q      <= '0;
         gnt_q     <= 1'b0;
         gnt_buf_q <= '0;
         err_ovf_q <= 1'b0;
         err_rel_q <= 1'b0;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         gnt_q     <= gnt_d;
         gnt_buf_q <= gnt_buf_d;
         err_ovf_q <= err_ovf_d;
         err_rel_q <= err_rel_d;
      end
   end

   always_comb begin
      free_cnt = '0;
      for (int i = 0; i < NUM_BUF; i++) begin
         if (slot[i].state == BUF_FREE) begin
            free_cnt = free_cnt + (IDX_W+1)'(1);
         end
      end
   end

   assign fe_gnt       = gnt_q;
   assign fe_gnt_buf   = gnt_buf_q;
   assign err_ovf      = err_ovf_q;
   assign err_rel      = err_rel_q;

   assign be_blk_vld   = slot[rp_q].state == BUF_FULL;
   assign be_blk_buf   = rp_q;
   assign be_blk_words = be_blk_vld ? slot[rp_q].cnt : '0;
   assign be_blk_last  = be_blk_vld && slot[rp_q].last;

   assign buf_free_cnt = free_cnt;
   assign sched_idle   = (free_cnt == (IDX_W+1)'(NUM_BUF)) && !gnt_q;

endmodule

// File: tb/tb_cr_prefix_buf_sched.sv
// Bench for cr_prefix_buf_sched: directed scenarios plus randomized traffic
// compared against a queue-based model of the buffer lifecycle.
module tb_cr_prefix_buf_sched;

   localparam int NB = 4;
   localparam int BW = 128;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fe_req, fe_wr, fe_blk_done, fe_blk_last;
   logic       be_blk_rdy, be_rel;
   logic [1:0] be_rel_buf;
   logic       fe_gnt, be_blk_vld, be_blk_last, sched_idle, err_ovf, err_rel;
   logic [1:0] fe_gnt_buf, be_blk_buf;
   logic [7:0] be_blk_words;
   logic [2:0] buf_free_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   cr_prefix_buf_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fe_req       (fe_req),
      .fe_gnt       (fe_gnt),
      .fe_gnt_buf   (fe_gnt_buf),
      .fe_wr        (fe_wr),
      .fe_blk_done  (fe_blk_done),
      .fe_blk_last  (fe_blk_last),
      .be_blk_vld   (be_blk_vld),
      .be_blk_buf   (be_blk_buf),
      .be_blk_words (be_blk_words),
      .be_blk_last  (be_blk_last),
      .be_blk_rdy   (be_blk_rdy),
      .be_rel       (be_rel),
      .be_rel_buf   (be_rel_buf),
      .buf_free_cnt (buf_free_cnt),
      .sched_idle   (sched_idle),
      .err_ovf      (err_ovf),
      .err_rel      (err_rel)
   );

   always #5 clk = ~clk;

   logic [20:0] obs_all;
   assign obs_all = {fe_gnt, fe_gnt_buf, be_blk_vld, be_blk_buf, be_blk_words,
                     be_blk_last, buf_free_cnt, sched_idle, err_ovf, err_rel};

   // Reference model: who owns each buffer, plus a queue of closed blocks in fill order.
   typedef enum {M_FREE, M_FILL, M_FULL, M_DRAIN} m_phase_e;
   m_phase_e m_phase [NB];
   int       m_words [NB];
   bit       m_last  [NB];
   int       m_offer_q [$];
   int       m_next_alloc, m_takes, m_gnt_buf;
   bit       m_gnt, m_err_ovf, m_err_rel;

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_phase[i] = M_FREE;
         m_words[i] = 0;
         m_last[i]  = 1'b0;
      end
      m_offer_q.delete();
      m_next_alloc = 0;
      m_takes      = 0;
      m_gnt_buf    = 0;
      m_gnt        = 1'b0;
      m_err_ovf    = 1'b0;
      m_err_rel    = 1'b0;
   endtask

   task automatic model_update();
      bit ovf, rel_ok, take, grant;
      int head;
      ovf    = m_gnt ? (fe_wr && m_words[m_gnt_buf] == BW) : (fe_wr || fe_blk_done);
      rel_ok = be_rel && m_phase[be_rel_buf] == M_DRAIN;
      take   = m_offer_q.size() > 0 && be_blk_rdy;
      grant  = !m_gnt && fe_req && m_phase[m_next_alloc] == M_FREE;
      if (m_gnt) begin
         if (fe_wr && m_words[m_gnt_buf] < BW) m_words[m_gnt_buf]++;
         if (fe_blk_done) begin
            m_phase[m_gnt_buf] = M_FULL;
            m_last[m_gnt_buf]  = fe_blk_last;
            m_offer_q.push_back(m_gnt_buf);
            m_gnt = 1'b0;
         end
      end
      if (take) begin
         head = m_offer_q.pop_front();
         m_phase[head] = M_DRAIN;
         m_takes++;
      end
      if (rel_ok) m_phase[be_rel_buf] = M_FREE;
      if (grant) begin
         m_phase[m_next_alloc] = M_FILL;
         m_words[m_next_alloc] = 0;
         m_last[m_next_alloc]  = 1'b0;
         m_gnt_buf    = m_next_alloc;
         m_gnt        = 1'b1;
         m_next_alloc = (m_next_alloc + 1) % NB;
      end
      m_err_ovf = ovf;
      m_err_rel = be_rel && !rel_ok;
   endtask

   function automatic logic [20:0] exp_all();
      int  free_n = 0;
      bit  vld    = m_offer_q.size() > 0;
      int  head   = vld ? m_offer_q[0] : 0;
      for (int i = 0; i < NB; i++) if (m_phase[i] == M_FREE) free_n++;
      return {m_gnt, 2'(m_gnt_buf), vld, 2'(m_takes % NB),
              vld ? 8'(m_words[head]) : 8'd0, vld && m_last[head],
              3'(free_n), (free_n == NB) && !m_gnt, m_err_ovf, m_err_rel};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      fe_req      = 1'b0;
      fe_wr       = 1'b0;
      fe_blk_done = 1'b0;
      fe_blk_last = 1'b0;
      be_blk_rdy  = 1'b0;
      be_rel      = 1'b0;
      be_rel_buf  = 2'd0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Grant, write n words, close with the given last flag.
   task automatic fill_block(input int n, input bit last);
      fe_req = 1'b1;
      tick();
      fe_req = 1'b0;
      fe_wr  = 1'b1;
      repeat (n) tick();
      fe_wr       = 1'b0;
      fe_blk_done = 1'b1;
      fe_blk_last = last;
      tick();
      fe_blk_done = 1'b0;
      fe_blk_last = 1'b0;
   endtask

   task automatic test_reset();
      logic [20:0] rst_val;
      rst_val = {1'b0, 2'd0, 1'b0, 2'd0, 8'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
      apply_reset();
      vec_cnt++;
      if (obs_all !== rst_val) begin
         err_cnt++;
         $display("FAIL reset_outputs: got %h want %h", obs_all, rst_val);
      end
   endtask

   task automatic test_single_block();
      apply_reset();
      fe_req = 1'b1;
      tick();
      fe_req = 1'b0;
      vec_cnt++;
      if (fe_gnt !== 1'b1 || fe_gnt_buf !== 2'd0) begin
         err_cnt++;
         $display("FAIL single_grant: got gnt=%0b buf=%0d want gnt=1 buf=0", fe_gnt, fe_gnt_buf);
      end
      fe_wr = 1'b1;
      repeat (BW) tick();
      fe_wr       = 1'b0;
      fe_blk_done = 1'b1;
      fe_blk_last = 1'b1;
      tick();
      fe_blk_done = 1'b0;
      fe_blk_last = 1'b0;
      vec_cnt++;
      if (be_blk_vld !== 1'b1 || be_blk_buf !== 2'd0 || be_blk_words !== 8'd128 ||
          be_blk_last !== 1'b1 || fe_gnt !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_offer: got vld=%0b buf=%0d words=%0d last=%0b gnt=%0b want 1 0 128 1 0",
                  be_blk_vld, be_blk_buf, be_blk_words, be_blk_last, fe_gnt);
      end
      be_blk_rdy = 1'b1;
      tick();
      be_blk_rdy = 1'b0;
      vec_cnt++;
      if (be_blk_vld !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_take: got vld=%0b want 0", be_blk_vld);
      end
      be_rel     = 1'b1;
      be_rel_buf = 2'd0;
      tick();
      be_rel = 1'b0;
      vec_cnt++;
      if (sched_idle !== 1'b1 || buf_free_cnt !== 3'd4 || err_rel !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_release: got idle=%0b free=%0d err_rel=%0b want 1 4 0",
                  sched_idle, buf_free_cnt, err_rel);
      end
   endtask

   task automatic test_ring_stall();
      apply_reset();
      for (int b = 0; b < NB; b++) fill_block(10, 1'b0);
      vec_cnt++;
      if (buf_free_cnt !== 3'd0 || be_blk_vld !== 1'b1 || be_blk_buf !== 2'd0 || be_blk_words !== 8'd10) begin
         err_cnt++;
         $display("FAIL ring_full: got free=%0d vld=%0b buf=%0d words=%0d want 0 1 0 10",
                  buf_free_cnt, be_blk_vld, be_blk_buf, be_blk_words);
      end
      fe_req = 1'b1;
      repeat (3) tick();
      vec_cnt++;
      if (fe_gnt !== 1'b0) begin
         err_cnt++;
         $display("FAIL ring_no_grant: got gnt=%0b want 0", fe_gnt);
      end
      be_blk_rdy = 1'b1;
      tick();
      be_blk_rdy = 1'b0;
      vec_cnt++;
      if (be_blk_vld !== 1'b1 || be_blk_buf !== 2'd1) begin
         err_cnt++;
         $display("FAIL ring_next_offer: got vld=%0b buf=%0d want 1 1", be_blk_vld, be_blk_buf);
      end
      be_rel     = 1'b1;
      be_rel_buf = 2'd0;
      tick();
      be_rel = 1'b0;
      vec_cnt++;
      if (fe_gnt !== 1'b0 || buf_free_cnt !== 3'd1) begin
         err_cnt++;
         $display("FAIL ring_rel_cycle: got gnt=%0b free=%0d want 0 1", fe_gnt, buf_free_cnt);
      end
      tick();
      fe_req = 1'b0;
      vec_cnt++;
      if (fe_gnt !== 1'b1 || fe_gnt_buf !== 2'd0) begin
         err_cnt++;
         $display("FAIL ring_regrant: got gnt=%0b buf=%0d want 1 0", fe_gnt, fe_gnt_buf);
      end
   endtask

   task automatic test_overflow();
      int pulses, first_idx;
      apply_reset();
      fe_wr = 1'b1;
      tick();
      fe_wr = 1'b0;
      vec_cnt++;
      if (err_ovf !== 1'b1) begin
         err_cnt++;
         $display("FAIL ovf_no_grant_wr: got err_ovf=%0b want 1", err_ovf);
      end
      fe_blk_done = 1'b1;
      tick();
      fe_blk_done = 1'b0;
      vec_cnt++;
      if (err_ovf !== 1'b1 || buf_free_cnt !== 3'd4) begin
         err_cnt++;
         $display("FAIL ovf_no_grant_done: got err_ovf=%0b free=%0d want 1 4", err_ovf, buf_free_cnt);
      end
      fe_req = 1'b1;
      tick();
      fe_req    = 1'b0;
      fe_wr     = 1'b1;
      pulses    = 0;
      first_idx = -1;
      for (int i = 0; i < BW + 2; i++) begin
         tick();
         if (err_ovf === 1'b1) begin
            if (first_idx < 0) first_idx = i;
            pulses++;
         end
      end
      fe_wr = 1'b0;
      vec_cnt++;
      if (pulses !== 2 || first_idx !== BW) begin
         err_cnt++;
         $display("FAIL ovf_pulses: got %0d pulses first at %0d want 2 first at %0d", pulses, first_idx, BW);
      end
      fe_blk_done = 1'b1;
      tick();
      fe_blk_done = 1'b0;
      vec_cnt++;
      if (be_blk_vld !== 1'b1 || be_blk_words !== 8'd128 || be_blk_last !== 1'b0 || err_ovf !== 1'b0) begin
         err_cnt++;
         $display("FAIL ovf_words: got vld=%0b words=%0d last=%0b err_ovf=%0b want 1 128 0 0",
                  be_blk_vld, be_blk_words, be_blk_last, err_ovf);
      end
   endtask

   task automatic test_zero_word();
      apply_reset();
      fe_req = 1'b1;
      tick();
      fe_blk_done = 1'b1;
      fe_blk_last = 1'b1;
      tick();
      fe_blk_done = 1'b0;
      fe_blk_last = 1'b0;
      vec_cnt++;
      if (be_blk_vld !== 1'b1 || be_blk_words !== 8'd0 || be_blk_last !== 1'b1 || fe_gnt !== 1'b0) begin
         err_cnt++;
         $display("FAIL zero_offer: got vld=%0b words=%0d last=%0b gnt=%0b want 1 0 1 0",
                  be_blk_vld, be_blk_words, be_blk_last, fe_gnt);
      end
      tick();
      fe_req = 1'b0;
      vec_cnt++;
      if (fe_gnt !== 1'b1 || fe_gnt_buf !== 2'd1) begin
         err_cnt++;
         $display("FAIL zero_next_grant: got gnt=%0b buf=%0d want 1 1", fe_gnt, fe_gnt_buf);
      end
   endtask

   task automatic test_ooo_release();
      apply_reset();
      fill_block(2, 1'b0);
      fill_block(2, 1'b1);
      be_blk_rdy = 1'b1;
      repeat (2) tick();
      be_blk_rdy = 1'b0;
      vec_cnt++;
      if (buf_free_cnt !== 3'd2 || be_blk_vld !== 1'b0) begin
         err_cnt++;
         $display("FAIL ooo_drained: got free=%0d vld=%0b want 2 0", buf_free_cnt, be_blk_vld);
      end
      be_rel     = 1'b1;
      be_rel_buf = 2'd1;
      tick();
      vec_cnt++;
      if (buf_free_cnt !== 3'd3 || err_rel !== 1'b0) begin
         err_cnt++;
         $display("FAIL ooo_rel1: got free=%0d err_rel=%0b want 3 0", buf_free_cnt, err_rel);
      end
      be_rel_buf = 2'd0;
      tick();
      vec_cnt++;
      if (buf_free_cnt !== 3'd4 || err_rel !== 1'b0 || sched_idle !== 1'b1) begin
         err_cnt++;
         $display("FAIL ooo_rel0: got free=%0d err_rel=%0b idle=%0b want 4 0 1", buf_free_cnt, err_rel, sched_idle);
      end
      be_rel_buf = 2'd2;
      tick();
      be_rel = 1'b0;
      vec_cnt++;
      if (err_rel !== 1'b1 || buf_free_cnt !== 3'd4) begin
         err_cnt++;
         $display("FAIL ooo_bad_rel: got err_rel=%0b free=%0d want 1 4", err_rel, buf_free_cnt);
      end
      tick();
      vec_cnt++;
      if (err_rel !== 1'b0) begin
         err_cnt++;
         $display("FAIL ooo_err_pulse: got err_rel=%0b want 0", err_rel);
      end
   endtask

   task automatic test_reset_mid();
      logic [20:0] rst_val;
      rst_val = {1'b0, 2'd0, 1'b0, 2'd0, 8'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
      apply_reset();
      fill_block(3, 1'b0);
      fill_block(3, 1'b1);
      fe_req = 1'b1;
      tick();
      fe_req = 1'b0;
      fe_wr  = 1'b1;
      repeat (50) tick();
      fe_wr = 1'b0;
      vec_cnt++;
      if (buf_free_cnt !== 3'd1 || fe_gnt !== 1'b1 || be_blk_vld !== 1'b1) begin
         err_cnt++;
         $display("FAIL mid_setup: got free=%0d gnt=%0b vld=%0b want 1 1 1", buf_free_cnt, fe_gnt, be_blk_vld);
      end
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (obs_all !== rst_val) begin
         err_cnt++;
         $display("FAIL mid_reset: got %h want %h", obs_all, rst_val);
      end
      apply_reset();
      fe_req = 1'b1;
      tick();
      fe_req = 1'b0;
      vec_cnt++;
      if (fe_gnt !== 1'b1 || fe_gnt_buf !== 2'd0) begin
         err_cnt++;
         $display("FAIL mid_regrant: got gnt=%0b buf=%0d want 1 0", fe_gnt, fe_gnt_buf);
      end
   endtask

   task automatic test_random();
      logic [20:0] want;
      int          done_pct;
      apply_reset();
      for (int c = 0; c < 4000; c++) begin
         done_pct    = (c < 2000) ? 4 : 1;
         fe_req      = ($urandom_range(0, 1) == 1);
         fe_wr       = ($urandom_range(0, 9) < 7);
         fe_blk_done = ($urandom_range(0, 99) < done_pct);
         fe_blk_last = ($urandom_range(0, 1) == 1);
         be_blk_rdy  = ($urandom_range(0, 2) == 0);
         be_rel      = ($urandom_range(0, 2) == 0);
         be_rel_buf  = 2'($urandom_range(0, NB - 1));
         tick();
         want = exp_all();
         vec_cnt++;
         if (obs_all !== want) begin
            err_cnt++;
            $display("FAIL random_cycle_%0d: got %h want %h", c, obs_all, want);
         end
      end
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      test_reset();
      test_single_block();
      test_ring_stall();
      test_overflow();
      test_zero_word();
      test_ooo_release();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
